alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequencer that owns the 8-bit, 16-opcode ALU (ADD … LTH, accumulator ops ADDA/MULA/MAC) and feeds it a program of instructions. It buffers up to DEPTH instructions loaded by a host. On `start` it issues them to the ALU strictly in load order, one at a time. Each result is returned over a valid/ready port. Between issues it parks the ALU on a harmless opcode, so the accumulator is touched exactly once per accumulator instruction.

## Interface
- DEPTH, 8: instruction queue entries, power of two, at least 2.
- IDLE_OP, 4'b1001: opcode driven to the ALU when nothing is being issued. AND has no accumulator side effect.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  host offers an instruction
- in_ready  out  1  instruction accepted at the edge where in_valid and in_ready are both high
- in_opcode  in  4  instruction opcode
- in_a  in  8  instruction operand A
- in_b  in  8  instruction operand B
- start  in  1  begin executing the queue; single-cycle pulse
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last result handshake
- alu_opcode  out  4  to ALU opcode
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_out  in  8  from ALU_Out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  result value
- res_index  out  clog2(DEPTH)  0-based position of the instruction within the run
- res_err  out  1  result was substituted: divide by zero

## Operation
- ALU contract:
  - Registered ALU; inputs are sampled every rising edge and alu_out is valid in the following cycle.
  - Accumulator is modified only by opcodes 0100, 0101 and 0110.
- Queue: circular FIFO with wr_ptr, rd_ptr and count (0..DEPTH); pointers wrap at DEPTH.
- in_ready = (state==IDLE) && (count<DEPTH). No loads are accepted while busy.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE, start high, count>0 after this edge's load → ISSUE, idx=0. Start with count==0 is ignored. Start while busy is ignored.
  - ISSUE: drive the head entry onto alu_*.
    - If head is opcode 0011 with b==0: drive IDLE_OP/0/0 instead; at the edge capture res_data=8'hFF, res_err=1; → RESULT.
    - Otherwise → WAIT.
  - WAIT: alu_* = IDLE_OP/0/0. At the edge capture res_data=alu_out, res_err=0; → RESULT.
  - RESULT: res_valid=1, with res_data, res_index and res_err stable. On the handshake edge, pop the head and increment idx.
    - If entries remain → ISSUE.
    - Otherwise → IDLE, and done=1 for the next cycle.
- Outside ISSUE, alu_opcode=IDLE_OP and alu_a=alu_b=0, always.
- busy = (state!=IDLE).
- A load and start in the same IDLE cycle: the load is included in the run.
- Reset (any time, including mid-run):
  - State → IDLE; queue empty; idx=0.
  - in_ready=1; busy=done=res_valid=res_err=0; res_data=0; res_index=0.
  - alu_opcode=IDLE_OP; alu_a=alu_b=0.
  - An interrupted run is lost. The ALU accumulator is not reset by this block.

## Timing
- Let E0 be the edge that samples start.
  - ISSUE occupies the cycle after E0.
  - The ALU samples the instruction at E1.
  - res_valid rises at E2.
- Throughput: 3 cycles per instruction with res_ready held high.
- Divide-by-zero instruction: 2 cycles; res_valid rises at E1 after its ISSUE.
- Backpressure: RESULT is held indefinitely while res_ready is low. The ALU sees only IDLE_OP during the stall, so the accumulator is unchanged.
- done goes high one edge after the final handshake. busy falls at that same edge.

## Test plan
- Single ADD:
  - Stimulus: load ADD a=10 b=5; start; res_ready=1.
  - Response: res_data=15, res_index=0 at E2; done pulses at E3; busy high for exactly 3 cycles; in_ready low while busy.
- Accumulator integrity:
  - Stimulus: force ALU acc=0; load MAC(8,1), MAC(4,2); hold res_ready low 5 cycles on each result.
  - Response: results 8 then 16; alu_opcode shows 0110 in exactly 2 cycles.
- Divide by zero:
  - Stimulus: load DIV(8,0), DIV(8,2).
  - Response: result 0 is FF with res_err=1 and opcode 0011 never driven for it; result 1 is 4 with res_err=0.
- Full and order:
  - Stimulus: load 8 ADDs (i,1), i=0..7; attempt a 9th.
  - Response: in_ready low after the 8th; 9th not accepted; results 1..8 with res_index 0..7 in order; queue empty after the run.
- Reset mid-run:
  - Stimulus: assert rst asynchronously after 2 of 4 results.
  - Response: all outputs at reset values immediately; a later start without a load leaves busy=0.
- Start edge cases:
  - Stimulus A: start with an empty queue. Response: ignored.
  - Stimulus B: start plus in_valid XOR(8,10) in the same cycle. Response: one result, 2.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction queue and issue FSM in front of a registered 8-bit ALU.
// Instructions run strictly in load order; the ALU sees IDLE_OP whenever nothing is issued.
module alu_sequencer #(
    parameter int         DEPTH   = 8,
    parameter logic [3:0] IDLE_OP = 4'b1001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               alu_opcode,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic [7:0]               alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [$clog2(DEPTH)-1:0] res_index,
    output logic                     res_err
);

    localparam int             IDX_W  = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL   = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] ONE    = (IDX_W + 1)'(1);
    localparam logic [3:0]     OP_DIV = 4'b0011;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t           state;
    logic [3:0]       q_op [DEPTH];
    logic [7:0]       q_a  [DEPTH];
    logic [7:0]       q_b  [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] rd_next;
    logic [IDX_W:0]   count;
    logic [IDX_W-1:0] idx;
    logic             issue_div0;

    logic             load;
    logic [3:0]       head_op;
    logic [7:0]       head_a;
    logic [7:0]       head_b;
    logic             head_div0;
    logic [3:0]       drv_op;
    logic [7:0]       drv_a;
    logic [7:0]       drv_b;

    assign in_ready = (state == IDLE) && (count != FULL);
    assign load     = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign rd_next  = rd_ptr + IDX_W'(1);

    // The entry that will be on the ALU in the next ISSUE cycle: a load landing on an
    // empty queue in the start cycle, or the entry behind the one being popped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        head_op = q_op[rd_ptr];
        head_a  = q_a[rd_ptr];
        head_b  = q_b[rd_ptr];
        if (state == IDLE && count == '0) begin
            head_op = in_opcode;
            head_a  = in_a;
            head_b  = in_b;
        end else if (state == RESULT) begin
            head_op = q_op[rd_next];
            head_a  = q_a[rd_next];
            head_b  = q_b[rd_next];
        end
    end

    // A divide by zero never reaches the ALU; it is parked instead.
    assign head_div0 = (head_op == OP_DIV) && (head_b == 8'd0);
    assign drv_op    = head_div0 ? IDLE_OP : head_op;
    assign drv_a     = head_div0 ? 8'd0 : head_a;
    assign drv_b     = head_div0 ? 8'd0 : head_b;

    // NOTE: queue storage has no reset; count and the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (load) begin
            q_op[wr_ptr] <= in_opcode;
            q_a[wr_ptr]  <= in_a;
            q_b[wr_ptr]  <= in_b;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            idx        <= '0;
            issue_div0 <= 1'b0;
            alu_opcode <= IDLE_OP;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            res_valid  <= 1'b0;
            res_data   <= 8'd0;
            res_index  <= '0;
            res_err    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        wr_ptr <= wr_ptr + IDX_W'(1);
                        count  <= count + ONE;
                    end
                    if (start && (count != '0 || load)) begin
                        state      <= ISSUE;
                        idx        <= '0;
                        issue_div0 <= head_div0;
                        alu_opcode <= drv_op;
                        alu_a      <= drv_a;
                        alu_b      <= drv_b;
                    end
                end
                ISSUE: begin
                    alu_opcode <= IDLE_OP;
                    alu_a      <= 8'd0;
                    alu_b      <= 8'd0;
                    if (issue_div0) begin
                        res_data  <= 8'hFF;
                        res_err   <= 1'b1;
                        res_index <= idx;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    res_data  <= alu_out;
                    res_err   <= 1'b0;
                    res_index <= idx;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rd_ptr    <= rd_next;
                        count     <= count - ONE;
                        idx       <= idx + IDX_W'(1);
                        if (count > ONE) begin
                            state      <= ISSUE;
                            issue_div0 <= head_div0;
                            alu_opcode <= drv_op;
                            alu_a      <= drv_a;
                            alu_b      <= drv_b;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: a registered ALU with accumulator around the sequencer, and a
// program-level model that predicts every result, checked on each handshake.
module tb_alu_sequencer;

    localparam logic [3:0] IDLE_OP = 4'b1001;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_opcode = 4'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [2:0] res_index;
    logic       res_err;

    int checks = 0;
    int errors = 0;

    instr_t     prog[$];
    res_t       exp_q[$];
    res_t       obs_q[$];
    logic [7:0] m_acc = 8'd0;
    logic [7:0] env_acc = 8'd0;
    logic       acc_clear = 1'b0;
    int         rr_mode = 0;
    int         stall_cnt = 0;
    int         mac_cycles = 0;
    bit         stalled = 1'b0;
    res_t       prev_res;

    alu_sequencer #(.DEPTH(8), .IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .start(start), .busy(busy), .done(done),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .res_err(res_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {new_acc, result}; only opcodes 4..6 change the accumulator.
    function automatic logic [15:0] alu_eval(input logic [3:0] op, input logic [7:0] a, b, acc);
        logic [7:0] o;
        logic [7:0] n;
        n = acc;
        o = 8'd0;
        case (op)
            4'd0:  o = a + b;
            4'd1:  o = a - b;
            4'd2:  o = a * b;
            4'd3:  o = (b == 8'd0) ? 8'hFF : a / b;
            4'd4:  begin n = acc + a;     o = n; end
            4'd5:  begin n = acc * a;     o = n; end
            4'd6:  begin n = acc + a * b; o = n; end
            4'd7:  o = ~a;
            4'd8:  o = a | b;
            4'd9:  o = a & b;
            4'd10: o = a ^ b;
            4'd11: o = a << 1;
            4'd12: o = a >> 1;
            4'd13: o = {7'd0, a == b};
            4'd14: o = {7'd0, a > b};
            default: o = {7'd0, a < b};
        endcase
        return {n, o};
    endfunction

    // The external ALU: samples its inputs on every edge, result valid next cycle.
    always @(posedge clk) begin : alu_env
        logic [15:0] r;
        r = alu_eval(alu_opcode, alu_a, alu_b, env_acc);
        alu_out <= r[7:0];
        env_acc <= acc_clear ? 8'd0 : r[15:8];
    end

    // Consumer: 0 = always ready, 1 = random backpressure, 2 = stall 5 cycles per result.
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: res_ready = 1'b1;
            1: res_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (res_valid) begin
                    if (stall_cnt < 5) begin
                        res_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end else begin
                    res_ready = 1'b0;
                    stall_cnt = 0;
                end
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the scoreboard and the idle/backpressure rules.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_low_while_busy", 32'(busy && in_ready), 32'd0);
            check("div0_never_driven", 32'(alu_opcode == 4'b0011 && alu_b == 8'd0), 32'd0);
            if (!busy) begin
                check("idle_alu_opcode", 32'(alu_opcode), 32'(IDLE_OP));
                check("idle_alu_ab", 32'({alu_a, alu_b}), 32'd0);
                check("idle_no_result", 32'(res_valid), 32'd0);
            end
            if (alu_opcode == 4'b0110) mac_cycles++;
            if (stalled) begin
                check("stall_valid_held", 32'(res_valid), 32'd1);
                check("stall_result_stable", 32'({res_data, res_index, res_err}), 32'(prev_res));
            end
            if (res_valid && res_ready) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_index", 32'(res_index), 32'(e.idx));
                    check("res_err", 32'(res_err), 32'(e.err));
                end
                obs_q.push_back({res_data, res_index, res_err});
            end
            stalled  = res_valid && !res_ready;
            prev_res = {res_data, res_index, res_err};
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_index", 32'(res_index), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'(IDLE_OP));
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    endtask

    task automatic load(input logic [3:0] op, input logic [7:0] a, b, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) prog.push_back('{op: op, a: a, b: b});
    endtask

    // Turns the loaded program into the result sequence it must produce.
    task automatic build_expected();
        logic [15:0] r;
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i].op == 4'd3 && prog[i].b == 8'd0) begin
                exp_q.push_back('{data: 8'hFF, idx: 3'(i), err: 1'b1});
            end else begin
                r = alu_eval(prog[i].op, prog[i].a, prog[i].b, m_acc);
                m_acc = r[15:8];
                exp_q.push_back('{data: r[7:0], idx: 3'(i), err: 1'b0});
            end
        end
        prog.delete();
    endtask

    task automatic pulse_start(input bit with_instr, input logic [3:0] op, input logic [7:0] a, b);
        bit acc;
        @(posedge clk);
        #1;
        start = 1'b1;
        if (with_instr) begin
            in_valid  = 1'b1;
            in_opcode = op;
            in_a      = a;
            in_b      = b;
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        if (acc) prog.push_back('{op: op, a: a, b: b});
    endtask

    task automatic start_run(input bit with_instr, input logic [3:0] op, input logic [7:0] a, b,
                             output int busy_cyc, output int lat);
        bit ran;
        bit got_done;
        obs_q.delete();
        pulse_start(with_instr, op, a, b);
        ran = (prog.size() != 0);
        build_expected();
        busy_cyc = 0;
        lat      = -1;
        got_done = 1'b0;
        if (ran) begin
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (busy) busy_cyc++;
                if (res_valid && lat < 0) lat = c;
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
            end
            check("done_seen", 32'(got_done), 32'd1);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("results_drained", 32'(exp_q.size()), 32'd0);
        end else begin
            repeat (5) begin
                @(negedge clk);
                if (busy) busy_cyc++;
            end
            check("empty_start_ignored", 32'(busy_cyc), 32'd0);
        end
    endtask

    initial begin
        int  bc;
        int  lt;
        bit  ac;
        int  n;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;

        rr_mode = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // Single ADD: result at E2, done at E3, busy for three cycles.
        load(4'd0, 8'd10, 8'd5, ac);
        check("add_loaded", 32'(ac), 32'd1);
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);
        check("add_busy_cycles", 32'(bc), 32'd3);
        check("add_latency", 32'(lt), 32'd2);
        check("add_count", 32'(obs_q.size()), 32'd1);
        check("add_value", 32'(obs_q[0].data), 32'd15);
        check("add_index", 32'(obs_q[0].idx), 32'd0);

        // Accumulator touched exactly once per MAC despite long stalls.
        @(posedge clk);
        #1 acc_clear = 1'b1;
        @(posedge clk);
        #1 acc_clear = 1'b0;
        m_acc      = 8'd0;
        mac_cycles = 0;
        rr_mode    = 2;
        load(4'd6, 8'd8, 8'd1, ac);
        load(4'd6, 8'd4, 8'd2, ac);
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);
        check("mac_count", 32'(obs_q.size()), 32'd2);
        check("mac_first", 32'(obs_q[0].data), 32'd8);
        check("mac_second", 32'(obs_q[1].data), 32'd16);
        check("mac_issue_cycles", 32'(mac_cycles), 32'd2);
        check("mac_acc_after", 32'(env_acc), 32'd16);
        rr_mode = 0;

        // Divide by zero is substituted and takes two cycles.
        load(4'd3, 8'd8, 8'd0, ac);
        load(4'd3, 8'd8, 8'd2, ac);
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);
        check("div0_latency", 32'(lt), 32'd1);
        check("div0_value", 32'(obs_q[0].data), 32'hFF);
        check("div0_err", 32'(obs_q[0].err), 32'd1);
        check("div_value", 32'(obs_q[1].data), 32'd4);
        check("div_err", 32'(obs_q[1].err), 32'd0);

        // Full queue, refused ninth load, in-order results.
        for (int i = 0; i < 8; i++) begin
            load(4'd0, 8'(i), 8'd1, ac);
            check("full_load_accepted", 32'(ac), 32'd1);
        end
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        load(4'd0, 8'd99, 8'd1, ac);
        check("ninth_refused", 32'(ac), 32'd0);
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);
        check("full_count", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("full_order_value", 32'(obs_q[i].data), 32'(i + 1));
            check("full_order_index", 32'(obs_q[i].idx), 32'(i));
        end
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);

        // Asynchronous reset after two of four results.
        for (int i = 0; i < 4; i++) load(4'd0, 8'(i), 8'd2, ac);
        obs_q.delete();
        pulse_start(1'b0, 4'd0, 8'd0, 8'd0);
        build_expected();
        for (int c = 0; c < 200 && obs_q.size() < 2; c++) @(negedge clk);
        check("reset_two_results", 32'(obs_q.size()), 32'd2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_values();
        exp_q.delete();
        prog.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);

        // Load and start in the same cycle.
        start_run(1'b1, 4'd10, 8'd8, 8'd10, bc, lt);
        check("xor_count", 32'(obs_q.size()), 32'd1);
        check("xor_value", 32'(obs_q[0].data), 32'd2);

        // Random programs with random backpressure.
        rr_mode = 1;
        repeat (30) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                op = 4'($urandom_range(0, 15));
                a  = 8'($urandom);
                b  = (op == 4'd3 && $urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
                if (i == n - 1 && $urandom_range(0, 1) == 1) begin
                    start_run(1'b1, op, a, b, bc, lt);
                end else begin
                    load(op, a, b, ac);
                    check("rand_load_accepted", 32'(ac), 32'd1);
                    if (i == n - 1) start_run(1'b0, 4'd0, 8'd0, 8'd0, bc, lt);
                end
            end
            check("rand_result_count", 32'(obs_q.size()), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
